// File: rtl/mlaccel_pkg.sv
// Shared definitions for the QPI link front end.
//   lanes_legal()   : true for the supported lane counts (1, 2, 4)
//   bits_per_edge() : data bits transferred per serial clock edge
//   RX_ENTRY_W      : receive FIFO entry width, {start flag, data byte}
package mlaccel_pkg;
  localparam int RX_ENTRY_W = 9;

  function automatic bit lanes_legal(input int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4);
  endfunction

  function automatic int bits_per_edge(input int lanes);
    return lanes;
  endfunction
endpackage

// File: rtl/mlaccel_sync_fifo.sv
// Synchronous FIFO with first-word-visible read data.
//   push/wdata : write when not full, or when full and popping the same cycle
//   pop/rdata  : rdata is the head entry; pop is ignored when empty
//   flush      : drops all entries (takes priority over push/pop)
//   full/empty/level : occupancy status; level carries one extra bit
module mlaccel_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign level   = cnt;
  assign rdata   = mem[rptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/mlaccel_qpi_link.sv
// QPI slave front end: oversamples pad csb/clk/io in the clock domain,
// deserialises bytes into an RX FIFO and serialises TX FIFO bytes out.
//   qpi_*_di        : pad inputs (csb active-low, serial clock, LANES data)
//   qpi_io_do/_oe   : pad data outputs and per-lane enables
//   qpi_rdy_do      : RX FIFO has at least 2 free entries (registered)
//   qpi_err_do      : low after an RX overflow in the current transaction
//   active          : a transaction is in progress
//   din_*           : received byte stream, din_start marks first byte
//   dout_*          : transmit byte stream, accepted only while active
//   rx_level        : RX FIFO occupancy
module mlaccel_qpi_link
  import mlaccel_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int RX_DEPTH    = 16,
  parameter int TX_DEPTH    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        qpi_csb_di,
  input  logic                        qpi_clk_di,
  input  logic [LANES-1:0]            qpi_io_di,
  output logic [LANES-1:0]            qpi_io_do,
  output logic [LANES-1:0]            qpi_io_oe,
  output logic                        qpi_rdy_do,
  output logic                        qpi_err_do,
  output logic                        active,
  output logic                        din_valid,
  input  logic                        din_ready,
  output logic                        din_start,
  output logic [7:0]                  din_data,
  input  logic                        dout_valid,
  output logic                        dout_ready,
  input  logic [7:0]                  dout_data,
  output logic [$clog2(RX_DEPTH):0]   rx_level
);
  localparam int BPE   = bits_per_edge(LANES);
  localparam int EDGES = 8 / BPE;
  localparam int LW    = $clog2(RX_DEPTH) + 1;

  if (!lanes_legal(LANES)) begin : g_bad_lanes
    $error("mlaccel_qpi_link: LANES must be 1, 2 or 4");
  end

  // Pad synchronisers. csb resets to "selected" so that a pad already low
  // when reset releases does not look like a fresh falling edge; only a
  // real high-then-low sequence opens a transaction.
  logic [SYNC_STAGES-1:0]            csb_sync, clk_sync;
  logic [SYNC_STAGES-1:0][LANES-1:0] io_sync;
  logic                              csb_d, clk_d;
  logic                              csb_s, clk_s;
  logic [LANES-1:0]                  io_s;

  always_ff @(posedge clock) begin
    if (reset) begin
      csb_sync <= '0;
      clk_sync <= '0;
      io_sync  <= '0;
      csb_d    <= 1'b0;
      clk_d    <= 1'b0;
    end else begin
      csb_sync <= {csb_sync[SYNC_STAGES-2:0], qpi_csb_di};
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], qpi_clk_di};
      io_sync  <= {io_sync[SYNC_STAGES-2:0], qpi_io_di};
      csb_d    <= csb_s;
      clk_d    <= clk_s;
    end
  end

  assign csb_s = csb_sync[SYNC_STAGES-1];
  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign io_s  = io_sync[SYNC_STAGES-1];

  logic csb_fall, csb_rise, clk_rise, clk_fall;
  assign csb_fall = ~csb_s & csb_d;
  assign csb_rise = csb_s & ~csb_d;
  assign clk_rise = clk_s & ~clk_d;
  assign clk_fall = ~clk_s & clk_d;

  logic       in_txn, first, ovf, oe, rdy, err;
  logic [3:0] rx_cnt, tx_cnt;
  logic [7:0] rx_sh, tx_sh;
  logic       run;
  assign run = in_txn & ~csb_fall & ~csb_rise;

  // RX datapath
  logic [7+LANES:0]      rx_cat;
  logic                  rx_done, rx_pop, rx_drop, rx_full, rx_empty;
  logic [RX_ENTRY_W-1:0] rx_rdata;

  assign rx_cat  = {rx_sh, io_s};
  assign rx_done = run & clk_rise & (rx_cnt == 4'(EDGES-1));
  assign rx_pop  = din_valid & din_ready;
  assign rx_drop = rx_done & rx_full & ~rx_pop;

  mlaccel_sync_fifo #(.WIDTH(RX_ENTRY_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rx_done),
    .wdata ({first, rx_cat[7:0]}),
    .pop   (rx_pop),
    .flush (1'b0),
    .rdata (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  assign din_valid = ~rx_empty;
  assign din_start = din_valid & rx_rdata[8];
  assign din_data  = din_valid ? rx_rdata[7:0] : 8'h00;

  // TX datapath
  logic                      tx_full, tx_empty, tx_load;
  logic [7:0]                tx_rdata;
  logic [$clog2(TX_DEPTH):0] tx_level_unused;

  assign tx_load    = run & clk_fall & (tx_cnt == 4'd0);
  assign dout_ready = ~tx_full & in_txn;

  mlaccel_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (dout_valid & dout_ready),
    .wdata (dout_data),
    .pop   (tx_load & ~tx_empty),
    .flush (csb_rise),
    .rdata (tx_rdata),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level_unused)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      in_txn <= 1'b0;
      first  <= 1'b0;
      ovf    <= 1'b0;
      oe     <= 1'b0;
      rdy    <= 1'b1;
      err    <= 1'b1;
      rx_cnt <= '0;
      tx_cnt <= '0;
      rx_sh  <= '0;
      tx_sh  <= '0;
    end else begin
      rdy <= (rx_level <= LW'(RX_DEPTH - 2));
      err <= ~ovf;
      if (csb_fall) begin
        in_txn <= 1'b1;
        first  <= 1'b1;
        ovf    <= 1'b0;
        rx_cnt <= '0;
        tx_cnt <= '0;
      end else if (csb_rise) begin
        // Partial RX byte is dropped by clearing the count; TX is idled.
        in_txn <= 1'b0;
        ovf    <= 1'b0;
        rx_cnt <= '0;
        tx_cnt <= '0;
        tx_sh  <= '0;
        oe     <= 1'b0;
      end else if (in_txn) begin
        if (clk_rise) begin
          rx_sh <= rx_cat[7:0];
          if (rx_cnt == 4'(EDGES-1)) begin
            rx_cnt <= '0;
            first  <= 1'b0;
            if (rx_drop) ovf <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 4'd1;
          end
        end
        if (clk_fall) begin
          // At a byte boundary an empty TX FIFO yields an idle slot.
          if (tx_cnt == 4'd0) begin
            tx_sh <= tx_empty ? 8'h00 : tx_rdata;
            oe    <= ~tx_empty;
          end else begin
            tx_sh <= tx_sh << BPE;
          end
          tx_cnt <= (tx_cnt == 4'(EDGES-1)) ? 4'd0 : tx_cnt + 4'd1;
        end
      end
    end
  end

  assign qpi_io_do  = tx_sh[7 -: LANES];
  assign qpi_io_oe  = {LANES{oe}};
  assign qpi_rdy_do = rdy;
  assign qpi_err_do = err;
  assign active     = in_txn;
endmodule

// File: tb/tb_mlaccel_qpi_link.sv
// Bench for mlaccel_qpi_link: a 4-lane instance (RX_DEPTH 4) and a 1-lane
// instance share the serial clock pad. A host-level model predicts received
// bytes into per-instance queues; monitors pop and compare on din transfers.
module tb_mlaccel_qpi_link;
  localparam int PH = 6;  // system cycles per serial clock half period

  logic clock = 0, reset = 0, clk_pad = 0;
  logic csb4 = 1, csb1 = 1;
  logic [3:0] io4 = 0;
  logic [0:0] io1 = 0;
  logic din_ready4 = 1, din_ready1 = 1;
  logic dout_valid4 = 0, dout_valid1 = 0;
  logic [7:0] dout_data4 = 0, dout_data1 = 0;

  logic [3:0] do4, oe4;
  logic [0:0] do1, oe1;
  logic rdy4, err4, act4, dv4, ds4, dr4;
  logic rdy1, err1, act1, dv1, ds1, dr1;
  logic [7:0] dd4, dd1;
  logic [2:0] lvl4;
  logic [4:0] lvl1;

  mlaccel_qpi_link #(.LANES(4), .RX_DEPTH(4), .TX_DEPTH(4), .SYNC_STAGES(2)) dut4 (
    .clock(clock), .reset(reset), .qpi_csb_di(csb4), .qpi_clk_di(clk_pad),
    .qpi_io_di(io4), .qpi_io_do(do4), .qpi_io_oe(oe4), .qpi_rdy_do(rdy4),
    .qpi_err_do(err4), .active(act4), .din_valid(dv4), .din_ready(din_ready4),
    .din_start(ds4), .din_data(dd4), .dout_valid(dout_valid4), .dout_ready(dr4),
    .dout_data(dout_data4), .rx_level(lvl4));

  mlaccel_qpi_link #(.LANES(1), .RX_DEPTH(16), .TX_DEPTH(2), .SYNC_STAGES(2)) dut1 (
    .clock(clock), .reset(reset), .qpi_csb_di(csb1), .qpi_clk_di(clk_pad),
    .qpi_io_di(io1), .qpi_io_do(do1), .qpi_io_oe(oe1), .qpi_rdy_do(rdy1),
    .qpi_err_do(err1), .active(act1), .din_valid(dv1), .din_ready(din_ready1),
    .din_start(ds1), .din_data(dd1), .dout_valid(dout_valid1), .dout_ready(dr1),
    .dout_data(dout_data1), .rx_level(lvl1));

  always #5 clock = ~clock;

  int ntot = 0, nbad = 0;
  int peak1 = 0;

  // Host-level model state, index 0 = 4-lane instance, 1 = 1-lane instance
  logic [8:0] exp4[$], exp1[$];
  logic [7:0] txq[$];
  bit         m_txn[2], m_first[2], m_ovf[2];
  logic [7:0] m_sh[2];
  int         m_cnt[2];
  logic [7:0] m_txb;
  bit         m_oe;
  int         m_tpos;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    ntot++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s got=%0h want=%0h", n, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Scoreboard monitors: a transfer happens at the next posedge.
  always @(negedge clock) begin
    if (!reset && dv4 && din_ready4) begin
      if (exp4.size() == 0) begin
        ntot++; nbad++;
        $display("FAIL din4_unexpected got=%0h want=none", {ds4, dd4});
      end else chk("din4", {ds4, dd4}, exp4.pop_front());
    end
    if (!reset && dv1 && din_ready1) begin
      if (exp1.size() == 0) begin
        ntot++; nbad++;
        $display("FAIL din1_unexpected got=%0h want=none", {ds1, dd1});
      end else chk("din1", {ds1, dd1}, exp1.pop_front());
    end
    if (int'(lvl1) > peak1) peak1 = int'(lvl1);
  end

  // A byte completed by the host lands in the FIFO unless it is full.
  task automatic complete(input int d);
    logic [8:0] e;
    e = {m_first[d], m_sh[d]};
    if (d == 0) begin
      if (exp4.size() < 4) exp4.push_back(e); else m_ovf[0] = 1;
    end else begin
      if (exp1.size() < 16) exp1.push_back(e); else m_ovf[1] = 1;
    end
    m_first[d] = 0;
  endtask

  task automatic csb_set(input int d, input logic v);
    if (d == 0) csb4 = v; else csb1 = v;
    m_txn[d] = !v;
    m_cnt[d] = 0;
    m_ovf[d] = 0;
    if (!v) m_first[d] = 1;
    if (d == 0) begin
      m_tpos = 0;
      if (v) begin txq.delete(); m_oe = 0; m_txb = 0; end
    end
    cyc(PH);
  endtask

  task automatic host_edge(input int d, input logic [3:0] v);
    logic [3:0] want;
    if (d == 0) io4 = v; else io1 = v[0];
    cyc(PH);
    clk_pad = 1;
    if (m_txn[d]) begin
      m_sh[d] = (d == 0) ? {m_sh[d][3:0], v} : {m_sh[d][6:0], v[0]};
      m_cnt[d]++;
      if (m_cnt[d] == ((d == 0) ? 2 : 8)) begin complete(d); m_cnt[d] = 0; end
    end
    cyc(PH);
    clk_pad = 0;
    want = 0;
    if (d == 0 && m_txn[0]) begin
      if (m_tpos == 0) begin
        if (txq.size() > 0) begin m_txb = txq.pop_front(); m_oe = 1; end
        else begin m_txb = 0; m_oe = 0; end
      end
      if (m_oe) want = (m_tpos == 0) ? m_txb[7:4] : m_txb[3:0];
      m_tpos = 1 - m_tpos;
    end
    cyc(PH);
    if (d == 0 && m_txn[0]) begin
      chk("tx_oe", oe4, {4{m_oe}});
      chk("tx_do", do4, want);
    end
  endtask

  task automatic host_byte(input int d, input logic [7:0] b);
    if (d == 0) begin
      host_edge(0, b[7:4]);
      host_edge(0, b[3:0]);
    end else begin
      for (int i = 7; i >= 0; i--) host_edge(1, {3'b000, b[i]});
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    bit ok;
    ok = 0;
    dout_valid4 = 1;
    dout_data4  = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      if (dr4) ok = 1;
    end
    @(posedge clock);
    #1 dout_valid4 = 0;
    if (ok) txq.push_back(b);
    else begin ntot++; nbad++; $display("FAIL dout_accept got=0 want=1"); end
  endtask

  task automatic do_reset();
    reset = 1;
    cyc(1);
    reset = 0;
    for (int d = 0; d < 2; d++) begin m_txn[d] = 0; m_cnt[d] = 0; m_ovf[d] = 0; end
    txq.delete(); exp4.delete(); exp1.delete();
    m_oe = 0; m_txb = 0; m_tpos = 0;
  endtask

  task automatic check_reset();
    chk("rst_dv4", dv4, 0);   chk("rst_ds4", ds4, 0);   chk("rst_dd4", dd4, 0);
    chk("rst_dr4", dr4, 0);   chk("rst_oe4", oe4, 0);   chk("rst_do4", do4, 0);
    chk("rst_rdy4", rdy4, 1); chk("rst_err4", err4, 1); chk("rst_act4", act4, 0);
    chk("rst_lvl4", lvl4, 0);
    chk("rst_dv1", dv1, 0);   chk("rst_dd1", dd1, 0);   chk("rst_oe1", oe1, 0);
    chk("rst_rdy1", rdy1, 1); chk("rst_err1", err1, 1); chk("rst_act1", act1, 0);
    chk("rst_lvl1", lvl1, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (exp4.size() > 0 || exp1.size() > 0); i++) cyc(1);
    chk("drain_left", exp4.size() + exp1.size(), 0);
  endtask

  initial begin
    cyc(2);
    do_reset();
    check_reset();
    cyc(4);

    // 4-lane receive of a fixed sequence
    csb_set(0, 0);
    host_byte(0, 8'h25); host_byte(0, 8'h34); host_byte(0, 8'h12);
    chk("t1_err", err4, 1);
    csb_set(0, 1);
    drain();

    // Transmit one byte over two slots
    csb_set(0, 0);
    push_tx(8'hC3);
    for (int i = 0; i < 4; i++) host_edge(0, 4'($urandom_range(0, 15)));
    csb_set(0, 1);
    drain();

    // Overflow with din stalled
    din_ready4 = 0;
    csb_set(0, 0);
    for (int k = 0; k < 5; k++) begin
      host_byte(0, 8'($urandom));
      chk("ovf_rdy", rdy4, (4 - exp4.size()) >= 2);
      chk("ovf_err", err4, !m_ovf[0]);
    end
    chk("ovf_level", lvl4, 4);
    csb_set(0, 1);
    din_ready4 = 1;
    drain();
    csb_set(0, 0);
    chk("ovf_err_new_txn", err4, 1);
    csb_set(0, 1);

    // Abort after one nibble with two TX bytes queued
    csb_set(0, 0);
    push_tx(8'($urandom)); push_tx(8'($urandom));
    host_edge(0, 4'($urandom_range(0, 15)));
    csb_set(0, 1);
    chk("abort_oe", oe4, 0);
    chk("abort_do", do4, 0);
    chk("abort_dv", dv4, 0);
    csb_set(0, 0);
    host_byte(0, 8'($urandom));
    csb_set(0, 1);
    drain();

    // Reset during the second byte
    csb_set(0, 0);
    host_byte(0, 8'($urandom));
    drain();
    host_edge(0, 4'($urandom_range(0, 15)));
    do_reset();
    check_reset();
    host_edge(0, 4'($urandom_range(0, 15)));
    host_edge(0, 4'($urandom_range(0, 15)));
    chk("rst_stay_idle", act4, 0);
    chk("rst_no_stale", dv4, 0);
    csb_set(0, 1);
    csb_set(0, 0);
    host_byte(0, 8'($urandom));
    csb_set(0, 1);
    drain();

    // Single-lane receive
    peak1 = 0;
    csb_set(1, 0);
    host_byte(1, 8'hA5);
    csb_set(1, 1);
    drain();
    chk("l1_peak", peak1, 1);
    csb_set(1, 0);
    host_byte(1, 8'($urandom)); host_byte(1, 8'($urandom));
    csb_set(1, 1);
    drain();

    // Random transactions on the 4-lane instance
    for (int t = 0; t < 6; t++) begin
      int n, ntx;
      n   = $urandom_range(1, 3);
      ntx = $urandom_range(0, 2);
      csb_set(0, 0);
      for (int j = 0; j < ntx; j++) push_tx(8'($urandom));
      for (int j = 0; j < n; j++) host_byte(0, 8'($urandom));
      csb_set(0, 1);
      chk("rand_oe_idle", oe4, 0);
      drain();
    end

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end
endmodule

// File: doc/mlaccel_qpi_link.md
# mlaccel_qpi_link

Parametrised, fully synchronous successor to the accelerator's QPI slave front end. Oversamples the host's serial clock, chip-select and data lanes in the `clock` domain and supports 1, 2 or 4 data lanes. Buffers received and transmitted bytes in FIFOs, drives real flow-control (`rdy`) and error (`err`) pins, and presents byte streams with valid/ready handshakes to the command state machine.

## Interface
- `LANES`, 4, number of data lanes; legal values 1, 2, 4; bits per pin edge.
- `RX_DEPTH`, 16, receive FIFO entries; power of two, minimum 4.
- `TX_DEPTH`, 16, transmit FIFO entries; power of two, minimum 2.
- `SYNC_STAGES`, 2, synchroniser flops on each pin input; minimum 2.
- `clock` in 1: system clock; must be at least 4x the `qpi_clk` frequency.
- `reset` in 1: synchronous, active-high.
- `qpi_csb_di` in 1: chip select from pad, active-low.
- `qpi_clk_di` in 1: serial clock from pad.
- `qpi_io_di` in LANES: data lanes from pad.
- `qpi_io_do` out LANES: data lanes to pad.
- `qpi_io_oe` out LANES: per-lane output enables; all lanes always equal.
- `qpi_rdy_do` out 1: high when the receive FIFO has at least 2 free entries.
- `qpi_err_do` out 1: active-low; 0 means a receive overflow occurred in the current transaction.
- `active` out 1: synchronised chip select is asserted.
- `din_valid` out 1, `din_ready` in 1, `din_start` out 1, `din_data` out 8: receive stream; `din_start` marks the first byte of a transaction.
- `dout_valid` in 1, `dout_ready` out 1, `dout_data` in 8: transmit stream.
- `rx_level` out $clog2(RX_DEPTH)+1: receive FIFO occupancy.

## Operation
- **Synchronisation:** `csb`, `clk` and `io` each pass through `SYNC_STAGES` flops. Edges of the synchronised clock are detected against a one-cycle-delayed copy.
- **Transaction boundaries:**
  - The falling edge of synchronised `csb` starts a transaction: `first` is set, the bit counter is cleared, and the overflow flag is cleared.
  - The rising edge of synchronised `csb` ends it: any partial receive byte is discarded, the TX FIFO is flushed, the TX shifter is cleared, and `io_oe` goes to 0.
  - RX FIFO contents survive `csb` deassertion.
- **Receive:**
  - On each rising clock edge with `csb` low, LANES bits shift in MSB-first.
  - After 8/LANES edges, the pair {first, byte} is pushed to the RX FIFO, then `first` is cleared.
  - If the FIFO is full (and not being popped in the same cycle), the byte is dropped and the sticky overflow flag is set; `qpi_err_do` then reads 0.
- **Transmit:**
  - On each falling clock edge at a byte boundary (transmit bit counter = 0), the block pops the TX FIFO if it is non-empty, loads the shifter, and sets `oe`.
  - If the TX FIFO is empty at that boundary, `oe` is 0 and `do` is 0 for the whole byte slot.
  - Remaining falling edges shift LANES bits out MSB-first.
  - The transmit bit counter advances only on falling edges and is cleared with `csb`.
- **FIFOs:**
  - Simultaneous push and pop is legal at any level, including full and empty.
  - Pointers wrap modulo depth; occupancy is held in an extra bit.
  - `dout_ready` = TX FIFO not full and `active`; bytes offered while inactive are not accepted.
- **Reset values:** both FIFOs empty; `din_valid` 0; `din_start` 0; `din_data` 0; `dout_ready` 0; `io_oe` 0; `io_do` 0; `rdy_do` 1; `err_do` 1; `active` 0; `rx_level` 0. Reset mid-transaction aborts it; a new transaction requires a fresh `csb` falling edge.

## Timing
- Pin edge to detected edge: SYNC_STAGES+1 cycles.
- Completing rising edge to `din_valid` high: SYNC_STAGES+2 cycles (FIFO write registered, first-word visible the next cycle).
- A `din` transfer occurs when `din_valid` and `din_ready` are both high; `din_data` is held stable while `din_valid` is high and `din_ready` is low.
- A `dout` transfer occurs when `dout_valid` and `dout_ready` are both high. The byte is eligible for the next byte boundary at least 1 cycle after the push.
- `io_do` and `io_oe` change 1 cycle after the detected falling edge, i.e. SYNC_STAGES+2 cycles after the pad edge.
- `rdy_do` and `err_do` are registered, updated 1 cycle after a FIFO level change or flag change.

## Structure
- Shared package `mlaccel_pkg`: lane-count legality check, `bits_per_edge` function, FIFO entry width constant (9 bits: start flag plus data).
- Sub-module `mlaccel_sync_fifo` (parameters `WIDTH`, `DEPTH`), with push/pop/flush, full, empty and level outputs. It is instantiated twice: RX with width 9, TX with width 8.

## Test plan
- **LANES=4, receive:** `csb` low, send 0x25 0x34 0x12 -> `din` yields {1,0x25}, {0,0x34}, {0,0x12}; `err_do`=1.
- **LANES=1, receive:** send 0xA5 over 8 edges -> a single `din` byte 0xA5 with `din_start`=1; `rx_level` peaks at 1.
- **Transmit:** push 0xC3 on `dout`, host clocks 2 byte slots with LANES=4 -> slot 1 drives nibbles C then 3 with `oe`=1; slot 2 has `oe`=0 and `do`=0.
- **Overflow:** RX_DEPTH=4, `din_ready`=0, send 5 bytes -> `rdy_do` falls after byte 3; byte 5 is dropped; `err_do`=0 until `csb` rises; bytes 1-4 are delivered intact.
- **Abort:** `csb` rises after 1 nibble with 2 TX bytes queued -> no `din` byte, TX FIFO empty, `oe`=0. The next transaction's first byte has `din_start`=1.
- **Reset mid-transfer:** assert `reset` for 1 cycle during byte 2 -> all outputs return to their reset values; no stale bytes appear.
